// File: rtl/ram_clear_sequencer_pkg.sv
// Shared definitions for the RAM clear sequencer and the display RAM path.
// Holds project-wide defaults and the sequencer state encoding.
package ram_clear_sequencer_pkg;

   localparam int DEF_DATA_WIDTH         = 16;
   localparam int DEF_RAM_REGISTER_COUNT = 1024;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

endpackage

// File: rtl/ram_clear_sequencer.sv
// Clears every RAM port-B word after reset or on request, holding the CPU,
// then hands port B to the display with stale read data masked.
module ram_clear_sequencer
   import ram_clear_sequencer_pkg::*;
#(
   parameter int                    DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int                    RAM_REGISTER_COUNT = DEF_RAM_REGISTER_COUNT,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE        = '0,
   localparam int                   ADDR_W             = $clog2(RAM_REGISTER_COUNT)
) (
   input  logic                  CLK_50,
   input  logic                  reset,
   input  logic                  clear_req,
   input  logic [ADDR_W-1:0]     vga_word_address,
   input  logic [DATA_WIDTH-1:0] ram_q_b,
   output logic [ADDR_W-1:0]     ram_address_b,
   output logic [DATA_WIDTH-1:0] ram_data_b,
   output logic                  ram_wren_b,
   output logic [DATA_WIDTH-1:0] vga_word_value,
   output logic                  cpu_hold,
   output logic                  clear_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_REGISTER_COUNT - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              read_valid_q, read_valid_d;
   logic              done_q, done_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      read_valid_d = 1'b0;
      unique case (state_q)
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            read_valid_d = !clear_req;
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
      // Reset restarts a full clear from address 0 and drops any pending done
      if (reset) begin
         state_d      = CLEAR;
         cnt_d        = '0;
         done_d       = 1'b0;
         read_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_50) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_valid_q <= read_valid_d;
      done_q       <= done_d;
   end

   always_comb begin
      ram_wren_b    = 1'b0;
      ram_address_b = vga_word_address;
      if (state_q == CLEAR) begin
         ram_address_b = cnt_q;
         ram_wren_b    = !reset;
      end
   end

   // Read data is only trusted when last cycle was a plain display read
   assign vga_word_value = (read_valid_q && !reset) ? ram_q_b : CLEAR_VALUE;
   assign ram_data_b     = CLEAR_VALUE;
   assign cpu_hold       = reset || (state_q == CLEAR) || done_q;
   assign clear_done     = done_q;

endmodule
